prbs_checker: RTL

Receive-side checker for the byte stream produced by the team's PRBS source. The stream is a preamble of `PATTERN` (4 bytes, MSB first) repeated `n` times, followed by PRBS-15 bytes. The block locks onto the preamble, self-seeds a local PRBS-15 LFSR from the received data, then compares every further byte against the prediction and accumulates bit errors. It sits on the link-receive side, fed by the same `data_valid`/byte interface the source drives.

---
 rtl/prbs_pkg.sv | 44 ++++
 rtl/prbs_checker_if.sv | 23 ++
 rtl/prbs_pattern_hunter.sv | 60 ++++++
 rtl/prbs_checker.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// Shared PRBS-15 definitions used by both the source and the checker so the two ends
// cannot drift apart.
package prbs_pkg;

    localparam int unsigned PRBS_W = 15;
    localparam int unsigned TAP_A  = 14;
    localparam int unsigned TAP_B  = 13;

    typedef logic [1:0] state_t;
    localparam state_t HUNT  = 2'd0;
    localparam state_t SEED  = 2'd1;
    localparam state_t CHECK = 2'd2;

    typedef struct packed {
        logic [PRBS_W-1:0] state;
        logic [7:0]        data;
    } step_t;

    // Eight steps of x^15+x^14+1; first generated bit lands in data[7].
    function automatic step_t prbs15_step8(input logic [PRBS_W-1:0] s);
        step_t             r;
        logic [PRBS_W-1:0] st;
        logic              b;
        st     = s;
        r.data = '0;
        for (int i = 0; i < 8; i++) begin
            b           = st[TAP_A] ^ st[TAP_B];
            st          = {st[PRBS_W-2:0], b};
            r.data[7-i] = b;
        end
        r.state = st;
        return r;
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/prbs_checker_if.sv
// Byte stream and status bundle between the link receiver and the PRBS checker.
interface prbs_checker_if;

    logic        data_valid;
    logic [7:0]  in;
    logic [7:0]  n;
    logic        err_clr;
    logic        pattern_locked;
    logic        prbs_locked;
    logic        err_pulse;
    logic [15:0] err_count;

    modport master (
        output data_valid, in, n, err_clr,
        input  pattern_locked, prbs_locked, err_pulse, err_count
    );

    modport slave (
        input  data_valid, in, n, err_clr,
        output pattern_locked, prbs_locked, err_pulse, err_count
    );

endinterface

// File: rtl/prbs_pattern_hunter.sv
// Preamble search: byte index within PATTERN plus a count of complete words seen in a row.
module prbs_pattern_hunter #(
    parameter logic [31:0] PATTERN = 32'hAABBCCDD
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       clr,
    input  logic       valid,
    input  logic [7:0] data,
    input  logic [7:0] n,
    output logic       found
);

    logic [1:0] idx_q, idx_d;
    logic [7:0] words_q, words_d;
    logic [7:0] exp_byte;
    logic       hit;

    always_comb begin
        unique case (idx_q)
            2'd0:    exp_byte = PATTERN[31:24];
            2'd1:    exp_byte = PATTERN[23:16];
            2'd2:    exp_byte = PATTERN[15:8];
            default: exp_byte = PATTERN[7:0];
        endcase
        hit   = (data == exp_byte);
        found = valid && hit && (idx_q == 2'd3) &&
                (({1'b0, words_q} + 9'd1) >= {1'b0, n});

        idx_d   = idx_q;
        words_d = words_q;
        if (clr) begin
            idx_d   = 2'd0;
            words_d = 8'd0;
        end else if (valid) begin
            if (found) begin
                idx_d   = 2'd0;
                words_d = 8'd0;
            end else if (hit) begin
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) words_d = words_q + 8'd1;
            end else begin
                // A broken byte may itself be the start of a fresh preamble word.
                words_d = 8'd0;
                idx_d   = (data == PATTERN[31:24]) ? 2'd1 : 2'd0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            idx_q   <= 2'd0;
            words_q <= 8'd0;
        end else begin
            idx_q   <= idx_d;
            words_q <= words_d;
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// Receive-side PRBS-15 checker: preamble lock, self-seeding LFSR, bit-error accounting.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter logic [31:0] PATTERN    = 32'hAABBCCDD,
    parameter int unsigned ERR_THRESH = 4
) (
    input logic           CLK,
    input logic           RSTn,
    prbs_checker_if.slave bus
);

    localparam logic [7:0] THRESH = 8'(ERR_THRESH);

    state_t            state_q, state_d;
    logic              seed_full_q, seed_full_d;
    logic [6:0]        seed_hi_q, seed_hi_d;
    logic [PRBS_W-1:0] lfsr_q, lfsr_d;
    logic [7:0]        consec_q, consec_d;
    logic              pat_lock_q, pat_lock_d;
    logic              prbs_lock_q, prbs_lock_d;
    logic              pulse_q, pulse_d;
    logic [15:0]       count_q, count_d;

    step_t             step;
    logic [3:0]        err;
    logic [16:0]       sum;
    logic [7:0]        consec_inc;
    logic [PRBS_W-1:0] seed_word;
    logic              found;

    prbs_pattern_hunter #(
        .PATTERN (PATTERN)
    ) u_hunter (
        .CLK   (CLK),
        .RSTn  (RSTn),
        .clr   (state_q != HUNT),
        .valid (bus.data_valid && (state_q == HUNT)),
        .data  (bus.in),
        .n     (bus.n),
        .found (found)
    );

    always_comb begin
        step       = prbs15_step8(lfsr_q);
        err        = popcount8(bus.in ^ step.data);
        sum        = {1'b0, count_q} + {13'd0, err};
        consec_inc = consec_q + 8'd1;
        seed_word  = {seed_hi_q, bus.in};

        state_d     = state_q;
        seed_full_d = seed_full_q;
        seed_hi_d   = seed_hi_q;
        lfsr_d      = lfsr_q;
        consec_d    = consec_q;
        pat_lock_d  = pat_lock_q;
        prbs_lock_d = prbs_lock_q;
        pulse_d     = 1'b0;
        count_d     = count_q;

        if (bus.data_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (bus.n == 8'd0) begin
                        // No preamble required: this byte is already seed byte 1.
                        state_d     = SEED;
                        pat_lock_d  = 1'b1;
                        seed_hi_d   = bus.in[6:0];
                        seed_full_d = 1'b1;
                    end else if (found) begin
                        state_d     = SEED;
                        pat_lock_d  = 1'b1;
                        seed_full_d = 1'b0;
                    end
                end
                SEED: begin
                    if (!seed_full_q) begin
                        seed_hi_d   = bus.in[6:0];
                        seed_full_d = 1'b1;
                    end else begin
                        seed_full_d = 1'b0;
                        if (seed_word != '0) begin
                            lfsr_d      = seed_word;
                            prbs_lock_d = 1'b1;
                            consec_d    = 8'd0;
                            state_d     = CHECK;
                        end
                    end
                end
                CHECK: begin
                    lfsr_d = step.state;
                    if (err != 4'd0) begin
                        pulse_d = 1'b1;
                        count_d = sum[16] ? 16'hFFFF : sum[15:0];
                        if (consec_inc >= THRESH) begin
                            prbs_lock_d = 1'b0;
                            consec_d    = 8'd0;
                            seed_full_d = 1'b0;
                            state_d     = SEED;
                        end else begin
                            consec_d = consec_inc;
                        end
                    end else begin
                        consec_d = 8'd0;
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        if (bus.err_clr) count_d = 16'd0;
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q     <= HUNT;
            seed_full_q <= 1'b0;
            seed_hi_q   <= 7'd0;
            lfsr_q      <= '0;
            consec_q    <= 8'd0;
            pat_lock_q  <= 1'b0;
            prbs_lock_q <= 1'b0;
            pulse_q     <= 1'b0;
            count_q     <= 16'd0;
        end else begin
            state_q     <= state_d;
            seed_full_q <= seed_full_d;
            seed_hi_q   <= seed_hi_d;
            lfsr_q      <= lfsr_d;
            consec_q    <= consec_d;
            pat_lock_q  <= pat_lock_d;
            prbs_lock_q <= prbs_lock_d;
            pulse_q     <= pulse_d;
            count_q     <= count_d;
        end
    end

    assign bus.pattern_locked = pat_lock_q;
    assign bus.prbs_locked    = prbs_lock_q;
    assign bus.err_pulse      = pulse_q;
    assign bus.err_count      = count_q;

endmodule
